// File: rtl/lsu_dbus_ctrl_pkg.sv
// lsu_dbus_ctrl_pkg: shared state, size, load-format and exception encodings for the LSU bus controller
package lsu_dbus_ctrl_pkg;
  localparam int LSU_STATE_WIDTH = 2;
  typedef enum logic [LSU_STATE_WIDTH-1:0] {
    LSU_IDLE   = 2'd0,
    LSU_REQ    = 2'd1,
    LSU_WAIT_R = 2'd2,
    LSU_DRAIN  = 2'd3
  } lsu_state_e;
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [4:0] L_MASK_LB  = 5'b10001;
  localparam logic [4:0] L_MASK_LBU = 5'b00001;
  localparam logic [4:0] L_MASK_LH  = 5'b10011;
  localparam logic [4:0] L_MASK_LHU = 5'b00011;
  localparam logic [4:0] L_MASK_LW  = 5'b11111;
  localparam logic [1:0] LSU_EXP_NONE        = 2'b00;
  localparam logic [1:0] LSU_EXP_LD_MISALIGN = 2'b01;
  localparam logic [1:0] LSU_EXP_ST_MISALIGN = 2'b10;
  localparam logic [1:0] LSU_EXP_BUS_ERR     = 2'b11;
  // Halfwords need an even address, words a 4-byte-aligned one; bytes are always aligned.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    return (size == SIZE_HALF && lo[0]) || (size == SIZE_WORD && lo != 2'b00);
  endfunction
endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align: selects the addressed byte/half of a bus word and sign/zero-extends it
module lsu_load_align
  import lsu_dbus_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      offset,
  input  logic [4:0]      l_mask,
  output logic [XLEN-1:0] data
);
  logic [7:0]  b;
  logic [15:0] h;
  // Lane select followed by extension; word loads pass through and ignore the sign bit.
  always_comb begin
    b    = rdata[8*offset +: 8];
    h    = offset[1] ? rdata[XLEN-1:XLEN-16] : rdata[15:0];
    data = l_mask[3:0] == L_MASK_LB[3:0] ? {{(XLEN-8){l_mask[4] & b[7]}}, b}
         : l_mask[3:0] == L_MASK_LH[3:0] ? {{(XLEN-16){l_mask[4] & h[15]}}, h}
         : rdata;
  end
endmodule

// File: rtl/lsu_dbus_ctrl.sv
// lsu_dbus_ctrl: issues one load/store at a time on a req/gnt + rvalid data bus and returns formatted load data
module lsu_dbus_ctrl
  import lsu_dbus_ctrl_pkg::*;
#(
  parameter int XLEN          = 32,
  parameter int RF_ADDR_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     pipe_flush,
  input  logic                     ex_mem_re,
  input  logic                     ex_mem_we,
  input  logic [XLEN-1:0]          ex_ls_addr,
  input  logic [1:0]               ex_size,
  input  logic [4:0]               ex_l_mask,
  input  logic [3:0]               ex_byte_we,
  input  logic [XLEN-1:0]          ex_mem_wdata,
  input  logic [RF_ADDR_WIDTH-1:0] ex_rf_waddr,
  output logic                     lsu_stall,
  output logic                     lsu_rdata_valid,
  output logic [XLEN-1:0]          lsu_rdata,
  output logic [RF_ADDR_WIDTH-1:0] lsu_rf_waddr,
  output logic                     lsu_exp_flag,
  output logic [1:0]               lsu_exp_cause,
  output logic                     dbus_req,
  output logic                     dbus_we,
  output logic [XLEN-1:0]          dbus_addr,
  output logic [3:0]               dbus_be,
  output logic [XLEN-1:0]          dbus_wdata,
  input  logic                     dbus_gnt,
  input  logic                     dbus_rvalid,
  input  logic [XLEN-1:0]          dbus_rdata,
  input  logic                     dbus_err
);
  lsu_state_e               state;
  logic [4:0]               l_mask_q;
  logic [1:0]               offset_q;
  logic [RF_ADDR_WIDTH-1:0] rf_waddr_q;
  logic [XLEN-1:0]          load_data;
  logic                     req_v;
  logic                     mis;
  logic                     accept;
  assign req_v    = ex_mem_re | ex_mem_we;
  assign mis      = is_misaligned(ex_size, ex_ls_addr[1:0]);
  assign accept   = rst_n && state == LSU_IDLE && req_v && !pipe_flush && !mis;
  assign dbus_req = state == LSU_REQ;
  lsu_load_align #(.XLEN(XLEN)) u_align (
    .rdata  (dbus_rdata),
    .offset (offset_q),
    .l_mask (l_mask_q),
    .data   (load_data)
  );
  // Stall holds the pipeline from acceptance until the response cycle, which releases it on the same edge.
  always_comb begin
    lsu_stall = state == LSU_IDLE ? accept
              : state == LSU_REQ  ? 1'b1
              : !dbus_rvalid;
  end
  // Request capture, bus handshake sequencing and registered result/exception pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= LSU_IDLE;
      dbus_we         <= 1'b0;
      dbus_addr       <= '0;
      dbus_be         <= '0;
      dbus_wdata      <= '0;
      l_mask_q        <= '0;
      offset_q        <= '0;
      rf_waddr_q      <= '0;
      lsu_rdata_valid <= 1'b0;
      lsu_rdata       <= '0;
      lsu_rf_waddr    <= '0;
      lsu_exp_flag    <= 1'b0;
      lsu_exp_cause   <= LSU_EXP_NONE;
    end else begin
      lsu_rdata_valid <= 1'b0;
      lsu_exp_flag    <= 1'b0;
      lsu_exp_cause   <= LSU_EXP_NONE;
      case (state)
        LSU_IDLE: begin
          if (accept) begin
            dbus_we    <= ex_mem_we;
            dbus_addr  <= {ex_ls_addr[XLEN-1:2], 2'b00};
            dbus_be    <= ex_mem_we ? ex_byte_we : 4'hF;
            dbus_wdata <= ex_mem_wdata;
            l_mask_q   <= ex_l_mask;
            offset_q   <= ex_ls_addr[1:0];
            rf_waddr_q <= ex_rf_waddr;
            state      <= LSU_REQ;
          end else if (req_v && !pipe_flush && mis) begin
            lsu_exp_flag  <= 1'b1;
            lsu_exp_cause <= ex_mem_we ? LSU_EXP_ST_MISALIGN : LSU_EXP_LD_MISALIGN;
          end
        end
        LSU_REQ: begin
          if (dbus_gnt) state <= pipe_flush ? LSU_DRAIN : LSU_WAIT_R;
          else if (pipe_flush) state <= LSU_IDLE;
        end
        LSU_WAIT_R: begin
          if (dbus_rvalid) begin
            state <= LSU_IDLE;
            if (!pipe_flush && dbus_err) begin
              lsu_exp_flag  <= 1'b1;
              lsu_exp_cause <= LSU_EXP_BUS_ERR;
            end else if (!pipe_flush && !dbus_we) begin
              lsu_rdata_valid <= 1'b1;
              lsu_rdata       <= load_data;
              lsu_rf_waddr    <= rf_waddr_q;
            end
          end else if (pipe_flush) begin
            state <= LSU_DRAIN;
          end
        end
        LSU_DRAIN: if (dbus_rvalid) state <= LSU_IDLE;
        default: state <= LSU_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_dbus_ctrl.sv
// tb_lsu_dbus_ctrl: directed and randomized checks of lsu_dbus_ctrl against a behavioural bus/load model
module tb_lsu_dbus_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pipe_flush = 1'b0;
  logic        ex_mem_re = 1'b0;
  logic        ex_mem_we = 1'b0;
  logic [31:0] ex_ls_addr = '0;
  logic [1:0]  ex_size = '0;
  logic [4:0]  ex_l_mask = '0;
  logic [3:0]  ex_byte_we = '0;
  logic [31:0] ex_mem_wdata = '0;
  logic [4:0]  ex_rf_waddr = '0;
  logic        lsu_stall;
  logic        lsu_rdata_valid;
  logic [31:0] lsu_rdata;
  logic [4:0]  lsu_rf_waddr;
  logic        lsu_exp_flag;
  logic [1:0]  lsu_exp_cause;
  logic        dbus_req;
  logic        dbus_we;
  logic [31:0] dbus_addr;
  logic [3:0]  dbus_be;
  logic [31:0] dbus_wdata;
  logic        dbus_gnt = 1'b0;
  logic        dbus_rvalid = 1'b0;
  logic [31:0] dbus_rdata = '0;
  logic        dbus_err = 1'b0;
  int passed = 0;
  int total = 0;

  typedef struct {
    int          stall;
    int          reqs;
    logic [68:0] bus;
    bit          unstable;
    int          vcnt;
    logic [31:0] rdata;
    logic [4:0]  waddr;
    int          ecnt;
    logic [1:0]  cause;
    bit          timeout;
  } obs_t;

  always #5 clk = ~clk;

  lsu_dbus_ctrl dut (
    .clk(clk), .rst_n(rst_n), .pipe_flush(pipe_flush),
    .ex_mem_re(ex_mem_re), .ex_mem_we(ex_mem_we), .ex_ls_addr(ex_ls_addr),
    .ex_size(ex_size), .ex_l_mask(ex_l_mask), .ex_byte_we(ex_byte_we),
    .ex_mem_wdata(ex_mem_wdata), .ex_rf_waddr(ex_rf_waddr),
    .lsu_stall(lsu_stall), .lsu_rdata_valid(lsu_rdata_valid), .lsu_rdata(lsu_rdata),
    .lsu_rf_waddr(lsu_rf_waddr), .lsu_exp_flag(lsu_exp_flag), .lsu_exp_cause(lsu_exp_cause),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr), .dbus_be(dbus_be),
    .dbus_wdata(dbus_wdata), .dbus_gnt(dbus_gnt), .dbus_rvalid(dbus_rvalid),
    .dbus_rdata(dbus_rdata), .dbus_err(dbus_err)
  );

  function automatic logic [31:0] ref_load(input logic [31:0] rd, input logic [31:0] a, input logic [4:0] lm);
    int bits;
    logic [31:0] v, m;
    bits = lm[3:0] == 4'b0001 ? 8 : lm[3:0] == 4'b0011 ? 16 : 32;
    if (bits == 32) return rd;
    v = rd >> (8 * (a % 4));
    m = (32'd1 << bits) - 32'd1;
    v = v & m;
    if (lm[4] && v[bits-1]) v = v | ~m;
    return v;
  endfunction

  // Presents one request for a single cycle, plays the bus side (gnt gd cycles into REQ,
  // rvalid rv cycles after the grant), optionally flushes in cycle fl, and records what it saw.
  task automatic run_access(input logic re, input logic we, input logic [31:0] addr, input logic [1:0] size,
                            input logic [4:0] lm, input logic [3:0] bwe, input logic [31:0] wd, input logic [4:0] wa,
                            input logic [31:0] rd, input logic err, input int gd, input int rv, input int fl,
                            input int limit, output obs_t o);
    int req_cnt, wcnt, after;
    bit granted, done;
    o = '{default: '0};
    req_cnt = 0; wcnt = 0; after = 0; granted = 0; done = 0;
    for (int c = 0; c < limit; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin
        ex_ls_addr = addr; ex_size = size; ex_l_mask = lm; ex_byte_we = bwe;
        ex_mem_wdata = wd; ex_rf_waddr = wa;
      end
      ex_mem_re = c == 0 ? re : 1'b0;
      ex_mem_we = c == 0 ? we : 1'b0;
      pipe_flush = c == fl;
      dbus_gnt = 1'b0; dbus_rvalid = 1'b0; dbus_err = 1'b0;
      if (granted && !done) begin
        if (wcnt == rv) begin dbus_rvalid = 1'b1; dbus_rdata = rd; dbus_err = err; done = 1; end
        wcnt++;
      end else if (dbus_req && !granted) begin
        if (req_cnt == gd) begin dbus_gnt = 1'b1; granted = 1; end
        req_cnt++;
      end
      @(negedge clk);
      if (lsu_stall) o.stall++;
      if (dbus_req) begin
        if (o.reqs == 0) o.bus = {dbus_we, dbus_be, dbus_addr, dbus_wdata};
        else if (o.bus !== {dbus_we, dbus_be, dbus_addr, dbus_wdata}) o.unstable = 1;
        o.reqs++;
      end
      if (lsu_rdata_valid) begin o.vcnt++; o.rdata = lsu_rdata; o.waddr = lsu_rf_waddr; end
      if (lsu_exp_flag) begin o.ecnt++; o.cause = lsu_exp_cause; end
      if (done) begin
        if (after == 1) break;
        after++;
      end
    end
    o.timeout = !done;
    pipe_flush = 1'b0; dbus_rvalid = 1'b0; dbus_gnt = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    total++; if ({lsu_stall, lsu_rdata_valid, lsu_rdata, lsu_rf_waddr, lsu_exp_flag, lsu_exp_cause} !== '0)
      $display("FAIL reset_lsu_outs got %h exp 0", {lsu_stall, lsu_rdata_valid, lsu_rdata, lsu_rf_waddr, lsu_exp_flag, lsu_exp_cause}); else passed++;
    total++; if ({dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata} !== '0)
      $display("FAIL reset_dbus_outs got %h exp 0", {dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata}); else passed++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_load_format();
    obs_t o;
    run_access(1, 0, 32'h1003, 2'b00, 5'b10001, 4'h0, 32'h0, 5'd5, 32'h80AB_CDEF, 0, 0, 1, -1, 20, o);
    total++; if (o.bus[68:32] !== {1'b0, 4'hF, 32'h1000}) $display("FAIL lb_bus got %h exp %h", o.bus[68:32], {1'b0, 4'hF, 32'h1000}); else passed++;
    total++; if (o.vcnt !== 1 || o.rdata !== 32'hFFFF_FF80) $display("FAIL lb_rdata got %0d/%h exp 1/ffffff80", o.vcnt, o.rdata); else passed++;
    total++; if (o.waddr !== 5'd5) $display("FAIL lb_waddr got %0d exp 5", o.waddr); else passed++;
    total++; if (o.stall !== 3) $display("FAIL lb_stall got %0d exp 3", o.stall); else passed++;
    run_access(1, 0, 32'h2002, 2'b01, 5'b00011, 4'h0, 32'h0, 5'd6, 32'h9234_5678, 0, 0, 0, -1, 20, o);
    total++; if (o.rdata !== 32'h0000_9234) $display("FAIL lhu_rdata got %h exp 00009234", o.rdata); else passed++;
    run_access(1, 0, 32'h2002, 2'b01, 5'b10011, 4'h0, 32'h0, 5'd6, 32'h9234_5678, 0, 0, 0, -1, 20, o);
    total++; if (o.rdata !== 32'hFFFF_9234) $display("FAIL lh_rdata got %h exp ffff9234", o.rdata); else passed++;
  endtask

  task automatic test_store_delayed_gnt();
    obs_t o;
    run_access(0, 1, 32'h3001, 2'b00, 5'b00001, 4'b0010, 32'h0000_5A00, 5'd0, 32'h0, 0, 4, 0, -1, 20, o);
    total++; if (o.bus !== {1'b1, 4'b0010, 32'h3000, 32'h0000_5A00}) $display("FAIL sb_bus got %h exp %h", o.bus, {1'b1, 4'b0010, 32'h3000, 32'h0000_5A00}); else passed++;
    total++; if (o.reqs !== 5 || o.unstable) $display("FAIL sb_req_hold got %0d/%0d exp 5/0", o.reqs, o.unstable); else passed++;
    total++; if (o.vcnt !== 0 || o.ecnt !== 0) $display("FAIL sb_pulses got %0d/%0d exp 0/0", o.vcnt, o.ecnt); else passed++;
    total++; if (o.stall !== 6) $display("FAIL sb_stall got %0d exp 6", o.stall); else passed++;
  endtask

  task automatic test_misaligned();
    obs_t o;
    run_access(1, 0, 32'h4002, 2'b10, 5'b11111, 4'h0, 32'h0, 5'd1, 32'h0, 0, 0, 0, -1, 4, o);
    total++; if (o.reqs !== 0 || o.stall !== 0) $display("FAIL lw_mis_bus got %0d/%0d exp 0/0", o.reqs, o.stall); else passed++;
    total++; if (o.ecnt !== 1 || o.cause !== 2'b01) $display("FAIL lw_mis_exp got %0d/%b exp 1/01", o.ecnt, o.cause); else passed++;
    run_access(0, 1, 32'h4001, 2'b01, 5'b00011, 4'b0011, 32'h0, 5'd1, 32'h0, 0, 0, 0, -1, 4, o);
    total++; if (o.reqs !== 0 || o.ecnt !== 1 || o.cause !== 2'b10) $display("FAIL sh_mis_exp got %0d/%0d/%b exp 0/1/10", o.reqs, o.ecnt, o.cause); else passed++;
  endtask

  task automatic test_flush();
    obs_t o;
    run_access(1, 0, 32'h5000, 2'b10, 5'b11111, 4'h0, 32'h0, 5'd3, 32'hDEAD_BEEF, 0, 0, 3, 3, 20, o);
    total++; if (o.vcnt !== 0 || o.ecnt !== 0 || o.timeout) $display("FAIL flush_wait_pulses got %0d/%0d/%0d exp 0/0/0", o.vcnt, o.ecnt, o.timeout); else passed++;
    total++; if (o.stall !== 5 || o.reqs !== 1) $display("FAIL flush_wait_drain got %0d/%0d exp 5/1", o.stall, o.reqs); else passed++;
    run_access(1, 0, 32'h5004, 2'b10, 5'b11111, 4'h0, 32'h0, 5'd4, 32'h1234_5678, 0, 0, 0, -1, 20, o);
    total++; if (o.vcnt !== 1 || o.rdata !== 32'h1234_5678 || o.stall !== 2) $display("FAIL after_drain_lw got %0d/%h/%0d exp 1/12345678/2", o.vcnt, o.rdata, o.stall); else passed++;
    run_access(1, 0, 32'h5008, 2'b10, 5'b11111, 4'h0, 32'h0, 5'd4, 32'hCAFE_F00D, 0, 0, 1, 1, 20, o);
    total++; if (o.vcnt !== 0 || o.stall !== 3 || o.timeout) $display("FAIL flush_with_gnt got %0d/%0d/%0d exp 0/3/0", o.vcnt, o.stall, o.timeout); else passed++;
    run_access(1, 0, 32'h500C, 2'b10, 5'b11111, 4'h0, 32'h0, 5'd4, 32'hCAFE_F00D, 1, 0, 0, 2, 20, o);
    total++; if (o.vcnt !== 0 || o.ecnt !== 0 || o.stall !== 2) $display("FAIL flush_at_rvalid got %0d/%0d/%0d exp 0/0/2", o.vcnt, o.ecnt, o.stall); else passed++;
  endtask

  task automatic test_bus_err();
    obs_t o;
    run_access(1, 0, 32'h6000, 2'b10, 5'b11111, 4'h0, 32'h0, 5'd8, 32'h0BAD_0BAD, 1, 1, 1, -1, 20, o);
    total++; if (o.ecnt !== 1 || o.cause !== 2'b11 || o.vcnt !== 0) $display("FAIL bus_err got %0d/%b/%0d exp 1/11/0", o.ecnt, o.cause, o.vcnt); else passed++;
  endtask

  task automatic test_reset_in_req();
    @(posedge clk); #1;
    ex_mem_re = 1'b1; ex_ls_addr = 32'h40; ex_size = 2'b10; ex_l_mask = 5'b11111;
    @(posedge clk); #1;
    ex_mem_re = 1'b0;
    total++; if (dbus_req !== 1'b1) $display("FAIL rst_req_pre got %b exp 1", dbus_req); else passed++;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++; if (dbus_req !== 1'b0 || lsu_stall !== 1'b0) $display("FAIL rst_in_req got %b/%b exp 0/0", dbus_req, lsu_stall); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_back_to_back();
    @(posedge clk); #1;
    ex_mem_re = 1'b1; ex_ls_addr = 32'h100; ex_size = 2'b10; ex_l_mask = 5'b11111; ex_rf_waddr = 5'd7;
    @(negedge clk);
    total++; if (lsu_stall !== 1'b1) $display("FAIL b2b_accept_stall got %b exp 1", lsu_stall); else passed++;
    @(posedge clk); #1;
    dbus_gnt = 1'b1;
    @(posedge clk); #1;
    dbus_gnt = 1'b0; dbus_rvalid = 1'b1; dbus_rdata = 32'h1122_3344;
    @(negedge clk);
    total++; if (lsu_stall !== 1'b0) $display("FAIL b2b_rvalid_stall got %b exp 0", lsu_stall); else passed++;
    @(posedge clk); #1;
    dbus_rvalid = 1'b0; ex_ls_addr = 32'h104; ex_rf_waddr = 5'd9;
    @(negedge clk);
    total++; if (dbus_req !== 1'b0 || lsu_stall !== 1'b1) $display("FAIL b2b_second_accept got %b/%b exp 0/1", dbus_req, lsu_stall); else passed++;
    total++; if (lsu_rdata_valid !== 1'b1 || lsu_rdata !== 32'h1122_3344 || lsu_rf_waddr !== 5'd7)
      $display("FAIL b2b_first_data got %b/%h/%0d exp 1/11223344/7", lsu_rdata_valid, lsu_rdata, lsu_rf_waddr); else passed++;
    @(posedge clk); #1;
    ex_mem_re = 1'b0; dbus_gnt = 1'b1;
    @(negedge clk);
    total++; if (dbus_req !== 1'b1 || dbus_addr !== 32'h104) $display("FAIL b2b_second_req got %b/%h exp 1/104", dbus_req, dbus_addr); else passed++;
    @(posedge clk); #1;
    dbus_gnt = 1'b0; dbus_rvalid = 1'b1; dbus_rdata = 32'h5566_7788;
    @(posedge clk); #1;
    dbus_rvalid = 1'b0;
    @(negedge clk);
    total++; if (lsu_rdata_valid !== 1'b1 || lsu_rdata !== 32'h5566_7788 || lsu_rf_waddr !== 5'd9)
      $display("FAIL b2b_second_data got %b/%h/%0d exp 1/55667788/9", lsu_rdata_valid, lsu_rdata, lsu_rf_waddr); else passed++;
  endtask

  task automatic test_random();
    obs_t o;
    logic we, err, s;
    logic [1:0] sz, ec;
    logic [31:0] a, wd, rd, ev;
    logic [4:0] lm, wa;
    logic [3:0] bwe;
    int gd, rv, n, es, er, ee, evc;
    bit mis;
    for (int i = 0; i < 40; i++) begin
      we = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 2));
      n = 1 << sz;
      a = $urandom;
      if ($urandom_range(0, 2) != 0) a = a - (a % n);
      s = 1'($urandom_range(0, 1));
      lm = sz == 2 ? 5'b11111 : {s, sz == 1 ? 4'b0011 : 4'b0001};
      bwe = 4'(((1 << n) - 1) << (a % 4));
      wd = $urandom; rd = $urandom; wa = 5'($urandom);
      err = $urandom_range(0, 7) == 0;
      gd = $urandom_range(0, 3); rv = $urandom_range(0, 3);
      mis = (sz == 1 && a % 2 != 0) || (sz == 2 && a % 4 != 0);
      run_access(!we, we, a, sz, lm, bwe, wd, wa, rd, err, gd, rv, -1, mis ? 4 : 24, o);
      er  = mis ? 0 : gd + 1;
      es  = mis ? 0 : 2 + gd + rv;
      ee  = mis || err ? 1 : 0;
      ec  = mis ? (we ? 2'b10 : 2'b01) : err ? 2'b11 : 2'b00;
      evc = !mis && !we && !err ? 1 : 0;
      ev  = ref_load(rd, a, lm);
      total++; if (o.reqs !== er || o.stall !== es) $display("FAIL rnd%0d_req_stall got %0d/%0d exp %0d/%0d", i, o.reqs, o.stall, er, es); else passed++;
      total++; if (o.ecnt !== ee || o.cause !== ec) $display("FAIL rnd%0d_exp got %0d/%b exp %0d/%b", i, o.ecnt, o.cause, ee, ec); else passed++;
      total++; if (o.vcnt !== evc) $display("FAIL rnd%0d_valid got %0d exp %0d", i, o.vcnt, evc); else passed++;
      if (!mis) begin
        total++; if (o.timeout || o.unstable || o.bus !== {we, we ? bwe : 4'hF, a & 32'hFFFF_FFFC, wd})
          $display("FAIL rnd%0d_bus got %h t%0d u%0d exp %h", i, o.bus, o.timeout, o.unstable, {we, we ? bwe : 4'hF, a & 32'hFFFF_FFFC, wd}); else passed++;
      end
      if (evc == 1) begin
        total++; if (o.rdata !== ev || o.waddr !== wa) $display("FAIL rnd%0d_rdata got %h/%0d exp %h/%0d", i, o.rdata, o.waddr, ev, wa); else passed++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_format();
    test_store_delayed_gnt();
    test_misaligned();
    test_flush();
    test_bus_err();
    test_reset_in_req();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
